mem_access_unit: RTL

//  Memory-side counterpart of the register file's load-extension path. Accepts one load/store

---
 rtl/mem_access_unit_pkg.sv | 19 +
 rtl/mem_access_unit_lane.sv | 34 +++
 rtl/mem_access_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: request sizes and FSM states.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_RDW  = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  // Size code 3 is handled exactly like a word access.
  function automatic logic isWordSize(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// lane_extract_merge: combinational load extension and read-modify-write lane merge
// for a 32-bit word, shared by the load return path and the sub-word store path.
module lane_extract_merge
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    byteLane = word_i[{addr_lo_i, 3'b000} +: 8];
    halfLane = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    load_o   = word_i;
    merge_o  = word_i;
    if (isWordSize(size_i)) begin
      merge_o = wdata_i;
    end else if (size_i == SZ_HALF) begin
      load_o = {{16{~uns_i & halfLane[15]}}, halfLane};
      merge_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
    end else begin
      load_o = {{24{~uns_i & byteLane[7]}}, byteLane};
      merge_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit driving a word-wide RAM; sub-word stores use read-modify-write.
// Optional MISALIGN_CHECK_EN: misaligned half/word requests are answered with resp_err.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [2:0]        state_q, state_d;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q, rword_q, rdata_q;
  logic [ADDR_W+1:0] reqAddrEff;
  logic [31:0]       laneWord, loadWord, mergeWord;
  logic              accept;
  logic              unusedAddrHi;

  assign unusedAddrHi = ^req_addr[31:ADDR_W+2];
  assign req_ready    = (state_q == ST_IDLE);
  assign accept       = req_valid & req_ready;

`ifdef MISALIGN_CHECK_EN
  logic misaligned;
  logic err_q;

  assign misaligned = isWordSize(req_size) ? (|req_addr[1:0])
                                           : ((req_size == SZ_HALF) & req_addr[0]);
  assign reqAddrEff = req_addr[ADDR_W+1:0];
  assign resp_err   = err_q;
`else
  // Without the checker, misaligned low bits are simply dropped.
  always_comb begin
    reqAddrEff = req_addr[ADDR_W+1:0];
    if (isWordSize(req_size)) begin
      reqAddrEff[1:0] = 2'b00;
    end else if (req_size == SZ_HALF) begin
      reqAddrEff[0] = 1'b0;
    end
  end
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (req_we && isWordSize(req_size)) ? ST_WR : ST_RD;
      ST_RD:   state_d = ST_RDW;
      ST_RDW:  state_d = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef MISALIGN_CHECK_EN
    if ((state_q == ST_IDLE) && accept && misaligned) state_d = ST_RESP;
`endif
  end

  // In RDW the fresh RAM word feeds extraction directly; in WR the captured copy is merged.
  assign laneWord = (state_q == ST_RDW) ? mem_rdata : rword_q;

  lane_extract_merge u_lane (
    .word_i   (laneWord),
    .addr_lo_i(addr_q[1:0]),
    .size_i   (size_q),
    .uns_i    (uns_q),
    .wdata_i  (wdata_q),
    .load_o   (loadWord),
    .merge_o  (mergeWord)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      rdata_q <= '0;
`ifdef MISALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= reqAddrEff;
        wdata_q <= req_wdata;
      end
      if (state_q == ST_RDW) rword_q <= mem_rdata;
      // Response data is only refreshed on entry to RESP so it holds between responses.
      if (state_d == ST_RESP) begin
        rdata_q <= ((state_q == ST_RDW) && !we_q) ? loadWord : 32'h0;
`ifdef MISALIGN_CHECK_EN
        err_q   <= (state_q == ST_IDLE);
`endif
      end
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign mem_en     = (state_q == ST_RD) || (state_q == ST_WR);
  assign mem_we     = (state_q == ST_WR);
  assign mem_addr   = addr_q[ADDR_W+1:2];
  assign mem_wdata  = (state_q == ST_WR) ? mergeWord : 32'h0;

endmodule
